// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that drives the select input of a downstream 4:1 mux.
// It grants one requester at a time. sel, grant and valid are all registered,
// and sel changes only on the edge that starts a new grant, so the mux output
// never sees a select change while valid is high. A grant ends on ack, when
// the requester withdraws, or when the optional timeout expires.
module mux_sel_arbiter #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ack,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       valid,
  output logic       timeout
);

  // The timeout value must fit in the counter. A setting that does not fit
  // stops elaboration.
  if (TIMEOUT < 0 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
    $error("mux_sel_arbiter: TIMEOUT must be in [0, 2**CNT_W - 1]");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = TIMEOUT_EN ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       sel_n;
  logic [3:0]       grant_n;
  logic             valid_n;
  logic             timeout_n;

  logic [1:0]       pick;
  logic             pick_hit;

  // Round-robin search: find the first active request, starting at ptr.
  always_comb begin
    logic [1:0] idx;
    // NOTE: every combinational output gets a default before any branch. If a
    // path leaves one unassigned, synthesis infers a latch.
    pick     = '0;
    pick_hit = 1'b0;
    idx      = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!pick_hit && req[idx]) begin
        pick     = idx;
        pick_hit = 1'b1;
      end
    end
  end

  // Next-state and next-output logic. In BUSY, ack has the highest priority,
  // then a withdrawn request, then the timeout.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    sel_n     = sel;
    grant_n   = grant;
    valid_n   = valid;
    timeout_n = 1'b0;

    case (state)
      IDLE: begin
        if (pick_hit) begin
          sel_n   = pick;
          grant_n = 4'b0001 << pick;
          valid_n = 1'b1;
          cnt_n   = '0;
          state_n = BUSY;
        end
      end

      BUSY: begin
        if (ack) begin
          // Normal release: the next search starts just past the source that
          // was served.
          ptr_n   = sel + 2'd1;
          valid_n = 1'b0;
          grant_n = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (!req[sel]) begin
          // Abort: ptr does not move, so this source is still first in line
          // if it requests again.
          valid_n = 1'b0;
          grant_n = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (TIMEOUT_EN && cnt == CNT_LAST) begin
          ptr_n     = sel + 2'd1;
          valid_n   = 1'b0;
          grant_n   = '0;
          cnt_n     = '0;
          timeout_n = 1'b1;
          state_n   = IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  // NOTE: reset is asynchronous, so outputs go to their reset values as soon
  // as rst rises. They do not wait for the next clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Pointer, counter and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together, and simulation matches the synthesized hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      cnt     <= '0;
      sel     <= '0;
      grant   <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      sel     <= sel_n;
      grant   <= grant_n;
      valid   <= valid_n;
      timeout <= timeout_n;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter. The stimulus pushes each expected
// grant (the source index) into a queue. A monitor pops that queue whenever
// valid rises and compares sel and grant. Timing, timeout and reset behaviour
// are checked inline by the stimulus.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_q[$];

  mux_sel_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .sel     (sel),
    .grant   (grant),
    .valid   (valid),
    .timeout (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait, with a cycle budget, for valid to rise. Returns the number of edges
  // that passed.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!valid && cycles < 40);
    check("grant_seen", valid, 1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Monitor: on each new grant, compare against the next expected source.
  // While a grant is held, sel and grant must not change.
  initial begin
    logic       prev_valid;
    logic [1:0] prev_sel;
    logic [3:0] prev_grant;
    logic [1:0] e;
    prev_valid = 1'b0;
    prev_sel   = '0;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_grant_sel", {30'd0, sel}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("grant_sel", {30'd0, sel}, {30'd0, e});
            check("grant_onehot", {28'd0, grant}, {28'd0, 4'b0001 << e});
          end
        end else if (valid && prev_valid) begin
          check("sel_stable", {30'd0, sel}, {30'd0, prev_sel});
          check("grant_stable", {28'd0, grant}, {28'd0, prev_grant});
        end
        prev_valid = valid;
        prev_sel   = sel;
        prev_grant = grant;
      end
    end
  end

  // Watchdog: stop the run if it ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int hi;
    logic [1:0] rr_seq [5];
    rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd2;
    rr_seq[3] = 2'd3; rr_seq[4] = 2'd0;

    rst = 1'b1;
    req = '0;
    ack = 1'b0;
    repeat (3) tick();
    check("reset_sel", {30'd0, sel}, 0);
    check("reset_grant", {28'd0, grant}, 0);
    check("reset_valid", valid, 0);
    check("reset_timeout", timeout, 0);
    rst = 1'b0;
    tick();
    check("idle_no_req_valid", valid, 0);

    // A single request is granted one cycle later. An ack three edges after
    // the grant releases it.
    exp_q.push_back(2'd0);
    req = 4'b0001;
    tick();
    check("single_latency_valid", valid, 1);
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    req = '0;
    check("single_ack_release", valid, 0);

    // Reset pulse between edges so that ptr returns to 0.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    tick();

    // Fairness: all four request, and each grant is acked at once.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(rr_seq[i]);
      wait_valid(n);
      check("rr_gap_cycles", n, 1);
      pulse_ack();
      check("rr_release", valid, 0);
    end
    req = '0;
    // ptr = 1

    // Wrap and skip: grant source 2 (ptr becomes 3), then req 0101 picks 0,
    // then 2.
    req = 4'b0100;
    exp_q.push_back(2'd2);
    wait_valid(n);
    pulse_ack();
    req = 4'b0101;
    exp_q.push_back(2'd0);
    wait_valid(n);
    check("wrap_gap_cycles", n, 1);
    pulse_ack();
    exp_q.push_back(2'd2);
    wait_valid(n);
    pulse_ack();
    req = '0;
    // ptr = 3

    // Timeout: valid stays high 8 cycles, then one timeout pulse.
    req = 4'b0010;
    exp_q.push_back(2'd1);
    wait_valid(n);
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!valid) break;
      hi++;
    end
    check("timeout_valid_cycles", hi, 8);
    check("timeout_pulse", timeout, 1);
    req = 4'b1010;
    exp_q.push_back(2'd3);
    tick();
    check("timeout_pulse_one_cycle", timeout, 0);
    pulse_ack();
    req = '0;
    // ptr = 0

    // Collision: ack arrives on the edge where cnt == 7. Ack wins, no pulse.
    req = 4'b0001;
    exp_q.push_back(2'd0);
    wait_valid(n);
    repeat (7) tick();
    check("collision_still_busy", valid, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    req = '0;
    check("collision_release", valid, 0);
    check("collision_no_timeout", timeout, 0);
    tick();
    check("collision_no_timeout_next", timeout, 0);
    // ptr = 1

    // Withdraw: dropping req[sel] aborts and leaves ptr at 1, so source 2
    // is still first in line over source 3.
    req = 4'b0100;
    exp_q.push_back(2'd2);
    wait_valid(n);
    tick();
    check("withdraw_pre_busy", valid, 1);
    req = '0;
    tick();
    check("withdraw_release", valid, 0);
    check("withdraw_no_timeout", timeout, 0);
    req = 4'b1100;
    exp_q.push_back(2'd2);
    wait_valid(n);
    pulse_ack();
    req = '0;
    // ptr = 3

    // Asynchronous reset in the middle of a grant with sel = 2.
    req = 4'b0100;
    exp_q.push_back(2'd2);
    wait_valid(n);
    tick();
    check("pre_reset_sel", {30'd0, sel}, 2);
    #1 rst = 1'b1;
    #1;
    check("async_reset_sel", {30'd0, sel}, 0);
    check("async_reset_grant", {28'd0, grant}, 0);
    check("async_reset_valid", valid, 0);
    check("async_reset_timeout", timeout, 0);
    // ptr was cleared to 0, so req 1010 picks 1, not 3.
    req = 4'b1010;
    exp_q.push_back(2'd1);
    #1 rst = 1'b0;
    wait_valid(n);
    pulse_ack();
    req = '0;

    repeat (4) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
